// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// The FSM encoding is visible on the debug port, so keep these values stable.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO holding make codes. A push into a full buffer is dropped and
// latches a sticky overflow flag; a simultaneous pop makes room so both succeed.
module key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [PW:0]      r_count;
    logic             r_overflow;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == (PW+1)'(DEPTH));
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_data     = r_mem[r_rdPtr];

    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_doPush)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)
                r_rdPtr <= r_rdPtr + 1'b1;
            if (w_doPush && !w_doPop)
                r_count <= r_count + 1'b1;
            else if (w_doPop && !w_doPush)
                r_count <= r_count - 1'b1;
            if (i_push && !w_doPush)
                r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_doPush)
            r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: conditions the pad signals, deframes bytes,
// strips break/extended prefixes and queues make codes for the CPU read port.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        CLK_CPU,
    input  logic        resetp,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        clean_key_buffer,
    output logic [7:0]  pressed_key,
    output logic        keyboard_valid,
    output logic [31:0] debug
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]     r_clkSync;
    logic [1:0]     r_dataSync;
    logic           r_filtClk;
    logic [FCW-1:0] r_filtCnt;
    logic           r_fall;
    ps2_state_t     r_state;
    logic [2:0]     r_bitCnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_lastByte;
    logic [7:0]     r_errCnt;
    logic           r_breakPending;

    logic           w_clk;
    logic           w_data;
    logic           w_timeout;
    logic           w_stopFall;
    logic           w_frameGood;
    logic           w_errInc;
    logic           w_push;
    logic [7:0]     w_head;
    logic           w_empty;
    logic           w_full;
    logic [CW-1:0]  w_count;
    logic           w_overflow;

    assign w_clk  = r_clkSync[1];
    assign w_data = r_dataSync[1];

    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], PS2_CLK};
            r_dataSync <= {r_dataSync[0], PS2_DATA};
        end
    end

    // The fall strobe is registered together with the filtered level, so it
    // appears exactly FILTER_LEN cycles after the synchronised clock drops.
    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            r_filtClk <= 1'b1;
            r_filtCnt <= '0;
            r_fall    <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (w_clk == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FCW'(FILTER_LEN - 1)) begin
                r_filtClk <= w_clk;
                r_filtCnt <= '0;
                r_fall    <= ~w_clk;
            end else begin
                r_filtCnt <= r_filtCnt + 1'b1;
            end
        end
    end

    assign w_timeout   = (r_state != ST_IDLE) && !r_fall && (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_stopFall  = r_fall && (r_state == ST_STOP);
    assign w_frameGood = w_data && (^{r_shift, r_parity});
    assign w_errInc    = w_timeout || (w_stopFall && !w_frameGood);
    assign w_push      = w_stopFall && w_frameGood && !r_breakPending
                         && (r_shift != PS2_BREAK) && (r_shift != PS2_EXT);

    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_timer  <= '0;
        end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else if (r_fall) begin
            r_timer <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_data) begin
                        r_state  <= ST_DATA;
                        r_bitCnt <= '0;
                    end
                end
                ST_DATA: begin
                    r_shift  <= {w_data, r_shift[7:1]};
                    r_bitCnt <= r_bitCnt + 1'b1;
                    if (r_bitCnt == 3'd7)
                        r_state <= ST_PARITY;
                end
                ST_PARITY: begin
                    r_parity <= w_data;
                    r_state  <= ST_STOP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end else if (r_state != ST_IDLE) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // An E0 prefix leaves break_pending alone so "E0 F0 xx" is still a release.
    always_ff @(posedge CLK_CPU or posedge resetp) begin
        if (resetp) begin
            r_lastByte     <= '0;
            r_errCnt       <= '0;
            r_breakPending <= 1'b0;
        end else begin
            if (w_stopFall && w_frameGood) begin
                r_lastByte <= r_shift;
                if (r_shift == PS2_BREAK)
                    r_breakPending <= 1'b1;
                else if (r_shift != PS2_EXT)
                    r_breakPending <= 1'b0;
            end
            if (w_errInc && r_errCnt != 8'hFF)
                r_errCnt <= r_errCnt + 1'b1;
        end
    end

    key_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK_CPU),
        .rst        (resetp),
        .i_push     (w_push),
        .i_data     (r_shift),
        .i_pop      (clean_key_buffer),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    assign keyboard_valid = ~w_empty;
    assign pressed_key    = w_empty ? 8'h00 : w_head;
    assign debug = {8'h00, r_breakPending, w_overflow, r_state, 4'(w_count), r_errCnt, r_lastByte};

    logic w_unusedFull;
    assign w_unusedFull = w_full;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: each frame sent updates a reference
// model of the code filter and key queue, and pops are compared against it.
module tb_ps2_keyboard;

   localparam int HP  = 25;
   localparam int TMO = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic        ps2Clk;
   logic        ps2Data;
   logic        cleanKey;
   logic [7:0]  pressedKey;
   logic        kbValid;
   logic [31:0] debug;

   int checks = 0;
   int errors = 0;

   logic [7:0] expQ[$];
   bit         modelBreak;
   bit         modelOvf;
   int         modelErr;
   logic       valAt6;
   logic       valAt7;

   // Free-running 100 MHz-style system clock; only cycle counts matter here.
   always #5 clk = ~clk;

   ps2_keyboard #(
      .FIFO_DEPTH     (8),
      .FILTER_LEN     (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .CLK_CPU          (clk),
      .resetp           (rst),
      .PS2_CLK          (ps2Clk),
      .PS2_DATA         (ps2Data),
      .clean_key_buffer (cleanKey),
      .pressed_key      (pressedKey),
      .keyboard_valid   (kbValid),
      .debug            (debug)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
      checks++;
      if (obs !== expVal) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expVal);
      end
   endtask

   // One PS/2 bit: data set while the clock is high, then a full low phase.
   task automatic driveBit(input logic b);
      ps2Data = b;
      repeat (HP) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (HP) @(negedge clk);
      ps2Clk = 1'b1;
   endtask

   // Sends a frame; nBits < 8 abandons it mid-data. Complete frames update the
   // reference model. popOnPush pulses the pop exactly on the push edge.
   task automatic applyStimulus(input logic [7:0] code, input bit badParity,
                                input int nBits, input bit popOnPush);
      logic [7:0] head;
      driveBit(1'b0);
      for (int i = 0; i < nBits; i++)
         driveBit(code[i]);
      if (nBits < 8)
         return;
      driveBit(badParity ? ^code : ~^code);
      ps2Data = 1'b1;
      repeat (HP) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (6) @(negedge clk);
      valAt6 = kbValid;
      if (popOnPush) begin
         head = expQ.pop_front();
         checkOutput("popPushHead", 32'(pressedKey), 32'(head));
         cleanKey = 1'b1;
      end
      @(negedge clk);
      valAt7   = kbValid;
      cleanKey = 1'b0;
      repeat (HP - 7) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (20) @(negedge clk);
      if (badParity) begin
         modelErr++;
      end else if (code == 8'hF0) begin
         modelBreak = 1'b1;
      end else if (code == 8'hE0) begin
         modelBreak = modelBreak;
      end else if (modelBreak) begin
         modelBreak = 1'b0;
      end else if (expQ.size() < 8) begin
         expQ.push_back(code);
      end else begin
         modelOvf = 1'b1;
      end
   endtask

   // Compares the head against the scoreboard and pops one entry.
   task automatic popAndCheck(input string tag);
      logic [7:0] expKey;
      if (expQ.size() == 0) begin
         checkOutput({tag, "_noEntry"}, 32'(kbValid), 32'd0);
         return;
      end
      expKey = expQ.pop_front();
      checkOutput({tag, "_valid"}, 32'(kbValid), 32'd1);
      checkOutput(tag, 32'(pressedKey), 32'(expKey));
      cleanKey = 1'b1;
      @(negedge clk);
      cleanKey = 1'b0;
      @(negedge clk);
   endtask

   task automatic checkEmpty(input string tag);
      checkOutput({tag, "_valid"}, 32'(kbValid), 32'd0);
      checkOutput({tag, "_key"}, 32'(pressedKey), 32'h00);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      ps2Clk     = 1'b1;
      ps2Data    = 1'b1;
      cleanKey   = 1'b0;
      modelBreak = 1'b0;
      modelOvf   = 1'b0;
      modelErr   = 0;
      repeat (3) @(negedge clk);
      checkOutput("rstDebug", debug, 32'h0);
      checkEmpty("rst");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Single make code and push latency
      applyStimulus(8'h1C, 1'b0, 8, 1'b0);
      checkOutput("latBefore", 32'(valAt6), 32'd0);
      checkOutput("latAfter", 32'(valAt7), 32'd1);
      checkOutput("count1", 32'(debug[19:16]), 32'(expQ.size()));
      checkOutput("lastByte", 32'(debug[7:0]), 32'h1C);
      popAndCheck("key1C");
      checkEmpty("afterPop");

      // Release sequence is swallowed
      applyStimulus(8'hF0, 1'b0, 8, 1'b0);
      checkOutput("breakSet", 32'(debug[23]), 32'(modelBreak));
      applyStimulus(8'h1C, 1'b0, 8, 1'b0);
      checkOutput("breakClr", 32'(debug[23]), 32'(modelBreak));
      checkEmpty("release");
      applyStimulus(8'h32, 1'b0, 8, 1'b0);
      popAndCheck("key32");

      // Parity error, then timeout of a truncated frame
      applyStimulus(8'h1C, 1'b1, 8, 1'b0);
      checkEmpty("badParity");
      checkOutput("errParity", 32'(debug[15:8]), 32'(modelErr));
      applyStimulus(8'h55, 1'b0, 5, 1'b0);
      repeat (TMO + 10) @(negedge clk);
      modelErr++;
      checkOutput("tmoState", 32'(debug[21:20]), 32'd0);
      checkOutput("errTmo", 32'(debug[15:8]), 32'(modelErr));
      applyStimulus(8'h2D, 1'b0, 8, 1'b0);
      popAndCheck("key2D");

      // Overflow: nine codes into eight slots
      for (int k = 1; k <= 9; k++)
         applyStimulus(8'(k), 1'b0, 8, 1'b0);
      checkOutput("fullCount", 32'(debug[19:16]), 32'(expQ.size()));
      checkOutput("overflow", 32'(debug[22]), 32'(modelOvf));
      for (int k = 0; k < 8; k++)
         popAndCheck("ovfPop");
      checkEmpty("drained");

      // Pop and push on the same edge
      applyStimulus(8'h11, 1'b0, 8, 1'b0);
      applyStimulus(8'h22, 1'b0, 8, 1'b1);
      checkOutput("samePushCount", 32'(debug[19:16]), 32'(expQ.size()));
      popAndCheck("samePushKey");

      // Reset in the middle of a frame with entries queued
      applyStimulus(8'h41, 1'b0, 8, 1'b0);
      applyStimulus(8'h42, 1'b0, 8, 1'b0);
      applyStimulus(8'h43, 1'b0, 8, 1'b0);
      checkOutput("preRstCount", 32'(debug[19:16]), 32'(expQ.size()));
      applyStimulus(8'h5A, 1'b0, 3, 1'b0);
      checkOutput("preRstState", 32'(debug[21:20]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
      modelBreak = 1'b0;
      modelOvf   = 1'b0;
      modelErr   = 0;
      ps2Data    = 1'b1;
      checkOutput("midRstDebug", debug, 32'h0);
      checkEmpty("midRst");
      repeat (5) @(negedge clk);
      applyStimulus(8'h1C, 1'b0, 8, 1'b0);
      popAndCheck("postRstKey");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
